// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the E-stage HI/LO unit: op codes, FSM states and op-class helpers.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_mul(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage issue/result bundle between the pipeline and the HI/LO unit.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
    import muldiv_ctrl_pkg::*;

    logic             op_valid;
    md_op_e           op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall_e;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output op_valid, op, src_a, src_b, flush,
                    input  stall_e, busy, hi, lo);
    modport slave  (input  op_valid, op, src_a, src_b, flush,
                    output stall_e, busy, hi, lo);
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is resolved
// on the start edge so done pulses exactly WIDTH cycles after start.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done
);
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_rem_in, w_quo_in, w_dvs, w_rem_nx, w_quo_nx;
    logic [WIDTH:0]   w_shift, w_diff;

    always_comb begin
        w_rem_in = i_start ? '0 : r_rem;
        w_quo_in = i_start ? i_dividend : r_quo;
        w_dvs    = i_start ? i_divisor : r_dvs;
        w_shift  = {w_rem_in, w_quo_in[WIDTH-1]};
        w_diff   = w_shift - {1'b0, w_dvs};
        // Partial remainder stays below the divisor, so the MSB of the difference is the borrow.
        if (!w_diff[WIDTH]) begin
            w_rem_nx = w_diff[WIDTH-1:0];
            w_quo_nx = {w_quo_in[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nx = w_shift[WIDTH-1:0];
            w_quo_nx = {w_quo_in[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_abort) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_dvs  <= i_divisor;
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_done <= (WIDTH == 1);
        end else if (r_cnt != '0) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = r_done;
endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS E-stage HI/LO unit: owns HI/LO, sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO and stalls F/D/E while busy.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  md
);
    md_state_e r_state, w_state_nx;

    logic [WIDTH-1:0]   r_hi, r_lo, r_a;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg_q, r_neg_r, r_bzero;

    logic               w_accept, w_mul_go, w_div_go, w_signed, w_stall;
    logic               w_hi_we, w_lo_we, w_div_done;
    logic [WIDTH-1:0]   w_hi_d, w_lo_d, w_dvd, w_dvs, w_quo, w_rem;
    logic signed [WIDTH:0]     w_ma, w_mb;
    logic signed [2*WIDTH-1:0] w_prod;

    assign w_accept = (r_state == S_IDLE) && md.op_valid && !md.flush;
    assign w_mul_go = w_accept && op_is_mul(md.op);
    assign w_div_go = w_accept && op_is_div(md.op);
    assign w_signed = op_is_signed(md.op);

    // 33-bit extension lets a single signed multiplier serve both MULT and MULTU.
    assign w_ma   = {w_signed & md.src_a[WIDTH-1], md.src_a};
    assign w_mb   = {w_signed & md.src_b[WIDTH-1], md.src_b};
    assign w_prod = w_ma * w_mb;

    assign w_dvd = (w_signed && md.src_a[WIDTH-1]) ? -md.src_a : md.src_a;
    assign w_dvs = (w_signed && md.src_b[WIDTH-1]) ? -md.src_b : md.src_b;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_go),
        .i_abort     (md.flush),
        .i_dividend  (w_dvd),
        .i_divisor   (w_dvs),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done      (w_div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_stall    = 1'b0;
        w_hi_we    = 1'b0;
        w_lo_we    = 1'b0;
        w_hi_d     = md.src_a;
        w_lo_d     = md.src_a;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (md.op)
                        MD_MTHI: w_hi_we = 1'b1;
                        MD_MTLO: w_lo_we = 1'b1;
                        MD_MULT, MD_MULTU: begin
                            w_stall    = 1'b1;
                            w_state_nx = S_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_stall    = 1'b1;
                            w_state_nx = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                w_stall          = 1'b1;
                w_hi_we          = 1'b1;
                w_lo_we          = 1'b1;
                {w_hi_d, w_lo_d} = r_prod;
                w_state_nx       = S_DONE;
            end
            S_DIV: begin
                w_stall = 1'b1;
                if (w_div_done) begin
                    w_hi_we    = 1'b1;
                    w_lo_we    = 1'b1;
                    w_hi_d     = r_bzero ? r_a : (r_neg_r ? -w_rem : w_rem);
                    w_lo_d     = r_bzero ? '1  : (r_neg_q ? -w_quo : w_quo);
                    w_state_nx = S_DONE;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        // An annulled instruction releases the pipeline and never commits.
        if (md.flush) begin
            w_state_nx = S_IDLE;
            w_stall    = 1'b0;
            w_hi_we    = 1'b0;
            w_lo_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_prod  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
        end else begin
            if (w_hi_we) r_hi <= w_hi_d;
            if (w_lo_we) r_lo <= w_lo_d;
            if (w_mul_go) r_prod <= w_prod;
            if (w_div_go) begin
                r_a     <= md.src_a;
                r_neg_q <= w_signed & (md.src_a[WIDTH-1] ^ md.src_b[WIDTH-1]);
                r_neg_r <= w_signed & md.src_a[WIDTH-1];
                r_bzero <= (md.src_b == '0);
            end
        end
    end

    assign md.stall_e = w_stall;
    assign md.busy    = (r_state != S_IDLE);
    assign md.hi      = r_hi;
    assign md.lo      = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [W-1:0] m_hi, m_lo;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of one op from plain integer arithmetic; n = expected stall cycles.
    function automatic void model(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output int n);
        longint      sa, sb, q, r;
        logic [63:0] p;
        eh = m_hi;
        el = m_lo;
        n  = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p = 64'(sa * sb);
                {eh, el} = p;
                n = 2;
            end
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {eh, el} = p;
                n = 2;
            end
            MD_DIV, MD_DIVU: begin
                n = W + 1;
                if (b == 0) begin
                    el = '1;
                    eh = a;
                end else if (op == MD_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = 64'(q);
                    el = p[W-1:0];
                    p = 64'(r);
                    eh = p[W-1:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            MD_MTHI: eh = a;
            MD_MTLO: el = a;
            default: ;
        endcase
    endfunction

    task automatic do_op(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eh, el;
        int exp_n, n;
        model(op, a, b, eh, el, exp_n);
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.flush    = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.stall_e === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
            // Traffic while the unit is occupied must be ignored.
            bus.op_valid = 1'($urandom_range(0, 1));
            bus.op       = md_op_e'($urandom_range(0, 6));
            bus.src_a    = $urandom;
            bus.src_b    = $urandom;
            @(negedge clk);
        end
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", tag, n, exp_n);
        end
        if (exp_n > 0) begin
            checks++;
            if (bus.hi !== eh || bus.lo !== el || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL %s done_cycle hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=1",
                         tag, bus.hi, bus.lo, bus.busy, eh, el);
            end
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== eh || bus.lo !== el || bus.busy !== 1'b0 || bus.stall_e !== 1'b0) begin
            failures++;
            $display("FAIL %s after hi=%h lo=%h busy=%b stall=%b exp hi=%h lo=%h busy=0 stall=0",
                     tag, bus.hi, bus.lo, bus.busy, bus.stall_e, eh, el);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.op = MD_NONE;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.hi !== 0 || bus.lo !== 0 || bus.busy !== 1'b0 || bus.stall_e !== 1'b0) begin
            failures++;
            $display("FAIL reset hi=%h lo=%h busy=%b stall=%b exp all zero", bus.hi, bus.lo, bus.busy, bus.stall_e);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mult();
        do_op(MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult_neg2x3");
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
    endtask

    task automatic test_div();
        do_op(MD_DIV,  32'hFFFF_FFF9, 32'd2,         "div_neg7_2");
        do_op(MD_DIVU, 32'd100,       32'd0,         "divu_by_zero");
        do_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        do_op(MD_DIV,  32'd7,         32'hFFFF_FFFE, "div_7_neg2");
        do_op(MD_DIV,  32'hFFFF_FFF9, 32'd0,         "div_neg_by_zero");
    endtask

    task automatic test_mt_back_to_back();
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op = MD_MTHI;
        bus.src_a = 32'h1234;
        @(negedge clk);
        checks++;
        if (bus.stall_e !== 1'b0) begin
            failures++;
            $display("FAIL mthi_stall got=%b exp=0", bus.stall_e);
        end
        @(posedge clk); #1;
        bus.op = MD_MTLO;
        bus.src_a = 32'h5678;
        @(negedge clk);
        checks++;
        if (bus.stall_e !== 1'b0 || bus.hi !== 32'h1234) begin
            failures++;
            $display("FAIL mtlo_issue stall=%b hi=%h exp stall=0 hi=00001234", bus.stall_e, bus.hi);
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
            failures++;
            $display("FAIL mt_b2b hi=%h lo=%h exp hi=00001234 lo=00005678", bus.hi, bus.lo);
        end
        m_hi = 32'h1234;
        m_lo = 32'h5678;
    endtask

    task automatic test_mt_flush();
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.flush = 1'b1;
        bus.op = MD_MTHI;
        bus.src_a = 32'hAAAA_0001;
        @(posedge clk); #1;
        bus.op = MD_MTLO;
        bus.src_a = 32'hBBBB_0002;
        @(negedge clk);
        checks++;
        if (bus.stall_e !== 1'b0 || bus.hi !== m_hi) begin
            failures++;
            $display("FAIL mthi_flush stall=%b hi=%h exp stall=0 hi=%h", bus.stall_e, bus.hi, m_hi);
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL mt_flush hi=%h lo=%h exp hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    // Issue op, flush it at T+k, then check release, non-commit and a clean IDLE.
    task automatic flush_op(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int k, input string tag);
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall_e !== 1'b1) begin
            failures++;
            $display("FAIL %s issue_stall got=%b exp=1", tag, bus.stall_e);
        end
        for (int i = 1; i < k; i++) begin
            @(posedge clk); #1;
            bus.op_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall_e !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s flush_cycle stall=%b busy=%b exp stall=0 busy=1", tag, bus.stall_e, bus.busy);
        end
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL %s after_flush busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                     tag, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_flush();
        flush_op(MD_DIVU, 32'd100, 32'd7, 10, "flush_divu");
        do_op(MD_DIVU, 32'd100, 32'd7, "divu_after_flush");
        flush_op(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1, "flush_mult");
        flush_op(MD_DIV, 32'hDEAD_BEEF, 32'd3, W, "flush_div_last");
        do_op(MD_DIV, 32'hDEAD_BEEF, 32'd3, "div_after_late_flush");
    endtask

    task automatic test_random();
        md_op_e       op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = md_op_e'($urandom_range(0, 6));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'(b[7:0]);
            do_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end
    endtask

    task automatic test_reset_midop();
        do_op(MD_MTHI, 32'hCAFE_F00D, 32'd0, "preload_hi");
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op = MD_DIV;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        repeat (5) begin
            @(posedge clk); #1;
            bus.op_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.hi !== 0 || bus.lo !== 0 || bus.busy !== 1'b0 || bus.stall_e !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop hi=%h lo=%h busy=%b stall=%b exp all zero",
                     bus.hi, bus.lo, bus.busy, bus.stall_e);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        do_op(MD_DIVU, 32'd1000, 32'd3, "divu_after_reset");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_mt_back_to_back();
        test_mt_flush();
        test_flush();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Execute-stage HI/LO unit for the MIPS pipeline: owns the architectural HI and LO registers and sequences MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiplies complete in a fixed 3-cycle E-stage occupancy.
- Divides run on an iterative radix-2 divider for WIDTH cycles.
- The block stalls the pipeline while busy and abandons in-flight work on an exception flush.
- It sits beside the ALU in E; the decoder's hilowrite qualifies op_valid.

## Interface
- WIDTH, 32, operand/HI/LO width; also the divide iteration count
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  E-stage instruction is a HI/LO writer (hilowrite from decode)
- op  in  3  MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- src_a  in  WIDTH  rs value (dividend, multiplicand, MTHI/MTLO source)
- src_b  in  WIDTH  rt value (divisor, multiplier)
- flush  in  1  exception/annul of the E-stage instruction
- stall_e  out  1  hold F/D/E; combinational
- busy  out  1  state != IDLE; registered
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset values: state IDLE, hi=lo=0, iteration counter 0, busy=0, stall_e=0.
- IDLE, op_valid & !flush:
  - MTHI: hi<=src_a at the edge; no stall; stay IDLE.
  - MTLO: lo<=src_a at the edge; no stall; stay IDLE.
  - MULT/MULTU: latch operands, stall_e=1, go to MUL.
  - DIV/DIVU: latch operands and signedness, start div_iter, stall_e=1, go to DIV.
- MUL:
  - Product = 2*WIDTH-bit signed (MULT) or unsigned (MULTU) product of the latched operands.
  - {hi,lo}<=product at the edge; stall_e=1; go to DONE.
- DIV:
  - div_iter runs WIDTH iterations on |a| and |b| (signed) or raw a and b (unsigned).
  - Signed fix-up: quotient negated when operand signs differ; remainder takes the dividend's sign.
  - On div_iter done: lo<=quotient, hi<=remainder; go to DONE. stall_e=1 throughout DIV.
- DONE: stall_e=0 so the instruction leaves E at this edge; no new op is accepted; go to IDLE.
- Divisor zero: lo=all ones, hi=src_a (raw), same latency as a normal divide.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0 (two's-complement wrap).
- flush, any state:
  - stall_e=0 combinationally.
  - Next state IDLE; div_iter aborted.
  - hi/lo not written at that edge, including MTHI/MTLO issued with flush high.
- op_valid with MD_NONE, or while not IDLE: ignored.

## Timing
- Issue cycle T (IDLE accepts an op).
- MULT/MULTU:
  - stall_e high at T and T+1.
  - hi/lo updated at the end of T+1, visible at T+2 (DONE).
  - stall_e low at T+2. Total E occupancy 3 cycles.
- DIV/DIVU:
  - stall_e high at T..T+WIDTH.
  - hi/lo updated at the end of T+WIDTH, visible at T+WIDTH+1 (DONE).
  - stall_e low at T+WIDTH+1.
- MTHI/MTLO: 1 cycle; value visible at T+1.
- A dependent MFHI/MFLO in D during DONE reads the new value next cycle; forwarding is outside this block.
- Reset asserted mid-operation: immediate return to reset values; no partial hi/lo write.

## Structure
- Shared package: MD_* op encodings (3-bit) and the state enum.
- One sub-module, div_iter: unsigned restoring divider.
  - Ports: clk, rst, start, abort, dividend, divisor → quotient, remainder, done.
  - 6-bit counter; done is a one-cycle pulse after WIDTH iterations.
- Multiplier is inline: registered 64-bit product from sign- or zero-extended 33-bit operands.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_e high for exactly 2 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; stall_e high 33 cycles.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100/7 with flush at T+10 → stall_e drops that cycle; hi/lo keep prior values; state IDLE at T+11.
- MTHI 0x1234 then MTLO 0x5678 back-to-back → no stall; hi=0x1234, lo=0x5678. The same with flush high → hi/lo unchanged.
